mmio_ctrl: RTL and testbench

//  Parametrised memory-mapped I/O controller for the pipelined CPU's MEM stage. It decodes the
//  I/O page and gates data-memory writes. It owns registered HEX/LEDR/LEDG output registers,

---
 rtl/mmio_ctrl.sv | 179 +++++++++++++++++
 tb/tb_mmio_ctrl.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mmio_ctrl.sv
// Memory-mapped I/O controller for the CPU MEM stage: decodes the I/O page, gates data-memory
// writes, and holds the HEX/LED registers, synchronised switch/key inputs, key capture and a timer.
module mmio_ctrl #(
  parameter int         DBITS    = 32,
  parameter logic [3:0] IO_PAGE  = 4'hF,
  parameter int         NUM_SW   = 10,
  parameter int         NUM_KEYS = 4,
  parameter int         NUM_LEDR = 10,
  parameter int         NUM_LEDG = 8,
  parameter int         HEX_BITS = 16,
  parameter int         PRESCALE = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [DBITS-1:0]    dataAddr,
  input  logic [DBITS-1:0]    wrData,
  input  logic                isLoad,
  input  logic                isStore,
  input  logic [NUM_SW-1:0]   sw,
  input  logic [NUM_KEYS-1:0] key,
  output logic                dataWrtEn,
  output logic                ioRdHit,
  output logic [DBITS-1:0]    ioRdData,
  output logic [HEX_BITS-1:0] hexOut,
  output logic [NUM_LEDR-1:0] ledrOut,
  output logic [NUM_LEDG-1:0] ledgOut,
  output logic                irq
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic                io, ioWr;
  logic [7:0]          offset;
  logic                wrHex, wrLedr, wrLedg, wrKctrl, wrTcnt, wrTlim, wrTctrl;
  logic                keyChg, tick, tWrap;
  logic                unusedAddrBits;

  logic [HEX_BITS-1:0] hex_q, hex_d;
  logic [NUM_LEDR-1:0] ledr_q, ledr_d;
  logic [NUM_LEDG-1:0] ledg_q, ledg_d;
  logic [NUM_SW-1:0]   swSync1_q, swSync2_q;
  logic [NUM_KEYS-1:0] keySync1_q, keySync2_q, keyPrev_q;
  logic                kRdy_q, kRdy_d, kOvr_q, kOvr_d, kIe_q, kIe_d;
  logic                tRdy_q, tRdy_d, tOvr_q, tOvr_d, tIe_q, tIe_d;
  logic [DBITS-1:0]    tcnt_q, tcnt_d, tlim_q, tlim_d;
  logic [PW-1:0]       pre_q, pre_d;
  logic                irq_q, irq_d;
  logic [DBITS-1:0]    rdData;

  // A simultaneous load blocks any I/O store side effect.
  assign io        = (dataAddr[DBITS-1:DBITS-4] == IO_PAGE);
  assign dataWrtEn = isStore & ~io;
  assign ioRdHit   = isLoad & io;
  assign ioWr      = isStore & ~isLoad & io;
  assign offset    = dataAddr[7:0];
  assign unusedAddrBits = ^dataAddr[DBITS-5:8];

  assign wrHex   = ioWr && (offset == 8'h00);
  assign wrLedr  = ioWr && (offset == 8'h04);
  assign wrLedg  = ioWr && (offset == 8'h08);
  assign wrKctrl = ioWr && (offset == 8'h18);
  assign wrTcnt  = ioWr && (offset == 8'h20);
  assign wrTlim  = ioWr && (offset == 8'h24);
  assign wrTctrl = ioWr && (offset == 8'h28);

  assign keyChg = (keySync2_q != keyPrev_q);
  assign tick   = (pre_q == PRE_LAST);

  always_comb begin
    hex_d  = wrHex  ? wrData[HEX_BITS-1:0] : hex_q;
    ledr_d = wrLedr ? wrData[NUM_LEDR-1:0] : ledr_q;
    ledg_d = wrLedg ? wrData[NUM_LEDG-1:0] : ledg_q;

    // Capture events win over a same-cycle write-1-to-clear.
    kRdy_d = (kRdy_q & ~(wrKctrl & wrData[0])) | keyChg;
    kOvr_d = (kOvr_q & ~(wrKctrl & wrData[2])) | (keyChg & kRdy_q);
    kIe_d  = wrKctrl ? wrData[8] : kIe_q;

    tWrap  = 1'b0;
    tcnt_d = tcnt_q;
    tlim_d = tlim_q;
    pre_d  = tick ? '0 : pre_q + PW'(1);
    if (wrTcnt) begin
      tcnt_d = wrData;
      pre_d  = '0;
    end else if (wrTlim) begin
      tlim_d = wrData;
      tcnt_d = '0;
      pre_d  = '0;
    end else if (tick && (tlim_q != '0)) begin
      if (tcnt_q == tlim_q - DBITS'(1)) begin
        tcnt_d = '0;
        tWrap  = 1'b1;
      end else begin
        tcnt_d = tcnt_q + DBITS'(1);
      end
    end

    tRdy_d = (tRdy_q & ~(wrTctrl & wrData[0])) | tWrap;
    tOvr_d = (tOvr_q & ~(wrTctrl & wrData[2])) | (tWrap & tRdy_q);
    tIe_d  = wrTctrl ? wrData[8] : tIe_q;

    irq_d = (kRdy_d & kIe_d) | (tRdy_d & tIe_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hex_q      <= '0;
      ledr_q     <= '0;
      ledg_q     <= '0;
      swSync1_q  <= '0;
      swSync2_q  <= '0;
      keySync1_q <= '0;
      keySync2_q <= '0;
      keyPrev_q  <= '0;
      kRdy_q     <= 1'b0;
      kOvr_q     <= 1'b0;
      kIe_q      <= 1'b0;
      tRdy_q     <= 1'b0;
      tOvr_q     <= 1'b0;
      tIe_q      <= 1'b0;
      tcnt_q     <= '0;
      tlim_q     <= '0;
      pre_q      <= '0;
      irq_q      <= 1'b0;
    end else begin
      hex_q      <= hex_d;
      ledr_q     <= ledr_d;
      ledg_q     <= ledg_d;
      swSync1_q  <= sw;
      swSync2_q  <= swSync1_q;
      keySync1_q <= key;
      keySync2_q <= keySync1_q;
      keyPrev_q  <= keySync2_q;
      kRdy_q     <= kRdy_d;
      kOvr_q     <= kOvr_d;
      kIe_q      <= kIe_d;
      tRdy_q     <= tRdy_d;
      tOvr_q     <= tOvr_d;
      tIe_q      <= tIe_d;
      tcnt_q     <= tcnt_d;
      tlim_q     <= tlim_d;
      pre_q      <= pre_d;
      irq_q      <= irq_d;
    end
  end

  always_comb begin
    rdData = '0;
    case (offset)
      8'h00: rdData[HEX_BITS-1:0] = hex_q;
      8'h04: rdData[NUM_LEDR-1:0] = ledr_q;
      8'h08: rdData[NUM_LEDG-1:0] = ledg_q;
      8'h10: rdData[NUM_KEYS-1:0] = keySync2_q;
      8'h14: rdData[NUM_SW-1:0]   = swSync2_q;
      8'h18: begin
        rdData[0] = kRdy_q;
        rdData[2] = kOvr_q;
        rdData[8] = kIe_q;
      end
      8'h20: rdData = tcnt_q;
      8'h24: rdData = tlim_q;
      8'h28: begin
        rdData[0] = tRdy_q;
        rdData[2] = tOvr_q;
        rdData[8] = tIe_q;
      end
      default: rdData = '0;
    endcase
  end

  assign ioRdData = rdData;
  assign hexOut   = hex_q;
  assign ledrOut  = ledr_q;
  assign ledgOut  = ledg_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_mmio_ctrl.sv
// Directed bench for mmio_ctrl: bus decode, output registers, input sync, key capture and timer,
// with a two-cycle prescaler so timer events are quick to reach.
module tb_mmio_ctrl;

  localparam logic [31:0] A_HEX   = 32'hF000_0000;
  localparam logic [31:0] A_LEDR  = 32'hF000_0004;
  localparam logic [31:0] A_LEDG  = 32'hF000_0008;
  localparam logic [31:0] A_KDATA = 32'hF000_0010;
  localparam logic [31:0] A_SDATA = 32'hF000_0014;
  localparam logic [31:0] A_KCTRL = 32'hF000_0018;
  localparam logic [31:0] A_TCNT  = 32'hF000_0020;
  localparam logic [31:0] A_TLIM  = 32'hF000_0024;
  localparam logic [31:0] A_TCTRL = 32'hF000_0028;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataAddr, wrData;
  logic        isLoad, isStore;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic        dataWrtEn, ioRdHit, irq;
  logic [31:0] ioRdData;
  logic [15:0] hexOut;
  logic [9:0]  ledrOut;
  logic [7:0]  ledgOut;

  int total = 0;
  int bad   = 0;

  mmio_ctrl #(.PRESCALE(2)) dut (
    .clk(clk), .reset(reset), .dataAddr(dataAddr), .wrData(wrData),
    .isLoad(isLoad), .isStore(isStore), .sw(sw), .key(key),
    .dataWrtEn(dataWrtEn), .ioRdHit(ioRdHit), .ioRdData(ioRdData),
    .hexOut(hexOut), .ledrOut(ledrOut), .ledgOut(ledgOut), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // One store over a single clock edge; returns at the following negedge.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data);
    dataAddr = addr;
    wrData   = data;
    isStore  = 1'b1;
    @(negedge clk);
    isStore  = 1'b0;
    dataAddr = 32'h0;
    wrData   = 32'h0;
  endtask

  task automatic loadCheck(input string tag, input logic [31:0] addr, input logic [31:0] expected);
    dataAddr = addr;
    isLoad   = 1'b1;
    #1;
    checkOutput(tag, ioRdData, expected);
    isLoad   = 1'b0;
    dataAddr = 32'h0;
  endtask

  initial begin
    reset = 1'b1; dataAddr = 32'h0; wrData = 32'h0;
    isLoad = 1'b0; isStore = 1'b0; sw = 10'h0; key = 4'hF;
    repeat (2) @(negedge clk);
    checkOutput("rstHex", {16'h0, hexOut}, 32'h0);
    checkOutput("rstLedr", {22'h0, ledrOut}, 32'h0);
    checkOutput("rstIrq", {31'h0, irq}, 32'h0);
    loadCheck("rstTcnt", A_TCNT, 32'h0);
    reset = 1'b0;

    // First sample after reset sees keys nonzero vs a zero previous sample
    repeat (2) @(negedge clk);
    loadCheck("kctrlPre", A_KCTRL, 32'h0);
    @(negedge clk);
    loadCheck("kctrlFirst", A_KCTRL, 32'h1);
    applyStimulus(A_KCTRL, 32'h1);
    loadCheck("kctrlClr", A_KCTRL, 32'h0);

    // Page decode and output registers
    dataAddr = A_HEX; wrData = 32'h1234_ABCD; isStore = 1'b1;
    #1 checkOutput("wrEnIo", {31'h0, dataWrtEn}, 32'h0);
    @(negedge clk);
    isStore = 1'b0;
    checkOutput("hex", {16'h0, hexOut}, 32'h0000_ABCD);
    dataAddr = 32'h0000_0040; wrData = 32'hDEAD_BEEF; isStore = 1'b1;
    #1 checkOutput("wrEnMem", {31'h0, dataWrtEn}, 32'h1);
    @(negedge clk);
    isStore = 1'b0;
    checkOutput("hexKeep", {16'h0, hexOut}, 32'h0000_ABCD);
    applyStimulus(A_LEDR, 32'hFFFF_FFFF);
    checkOutput("ledrTrunc", {22'h0, ledrOut}, 32'h3FF);
    applyStimulus(A_LEDG, 32'h0000_01A5);
    checkOutput("ledgTrunc", {24'h0, ledgOut}, 32'hA5);
    loadCheck("hexRd", A_HEX, 32'h0000_ABCD);
    loadCheck("ledgRd", A_LEDG, 32'h0000_00A5);

    dataAddr = A_HEX; wrData = 32'h5555; isLoad = 1'b1; isStore = 1'b1;
    #1 checkOutput("ldPrioHit", {31'h0, ioRdHit}, 32'h1);
    @(negedge clk);
    isLoad = 1'b0; isStore = 1'b0;
    checkOutput("ldPrioHex", {16'h0, hexOut}, 32'h0000_ABCD);

    // Switch synchroniser latency and unmapped offset
    sw = 10'h2A5;
    loadCheck("sdata0", A_SDATA, 32'h0);
    @(negedge clk);
    loadCheck("sdata1", A_SDATA, 32'h0);
    @(negedge clk);
    loadCheck("sdata2", A_SDATA, 32'h2A5);
    dataAddr = 32'hF000_00FC; isLoad = 1'b1;
    #1 checkOutput("unmapHit", {31'h0, ioRdHit}, 32'h1);
    checkOutput("unmapData", ioRdData, 32'h0);
    isLoad = 1'b0;

    // Key change capture, overrun and set-beats-clear
    key = 4'hE;
    repeat (2) @(negedge clk);
    loadCheck("kdata", A_KDATA, 32'hE);
    loadCheck("kctrlWait", A_KCTRL, 32'h0);
    @(negedge clk);
    loadCheck("kctrlRdy", A_KCTRL, 32'h1);
    checkOutput("irqNoIe", {31'h0, irq}, 32'h0);
    key = 4'hF;
    repeat (3) @(negedge clk);
    loadCheck("kctrlOvr", A_KCTRL, 32'h5);
    key = 4'hE;
    repeat (2) @(negedge clk);
    applyStimulus(A_KCTRL, 32'h5);
    loadCheck("kctrlSetWins", A_KCTRL, 32'h5);
    applyStimulus(A_KCTRL, 32'h100);
    loadCheck("kctrlIe", A_KCTRL, 32'h105);
    checkOutput("irqKey", {31'h0, irq}, 32'h1);
    applyStimulus(A_KCTRL, 32'h5);
    loadCheck("kctrlW1c", A_KCTRL, 32'h0);
    checkOutput("irqKeyOff", {31'h0, irq}, 32'h0);

    // Timer: tick every 2 clocks, limit 3
    applyStimulus(A_TCTRL, 32'h100);
    applyStimulus(A_TLIM, 32'h3);
    loadCheck("tlim", A_TLIM, 32'h3);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      loadCheck($sformatf("tcnt%0d", i), A_TCNT, 32'((i / 2) % 3));
      loadCheck($sformatf("tctrl%0d", i), A_TCTRL,
                (i >= 12) ? 32'h105 : (i >= 6) ? 32'h101 : 32'h100);
      checkOutput($sformatf("tirq%0d", i), {31'h0, irq}, (i >= 6) ? 32'h1 : 32'h0);
    end

    // The prescaler is now one cycle from a tick: the store must win
    @(negedge clk);
    applyStimulus(A_TCNT, 32'h7);
    loadCheck("tcntWrWins", A_TCNT, 32'h7);
    @(negedge clk);
    loadCheck("tcntHold", A_TCNT, 32'h7);
    @(negedge clk);
    loadCheck("tcntPast", A_TCNT, 32'h8);

    applyStimulus(A_TCTRL, 32'h5);
    loadCheck("tctrlClr", A_TCTRL, 32'h0);
    applyStimulus(A_TLIM, 32'h0);
    applyStimulus(A_TCNT, 32'h5);
    repeat (6) @(negedge clk);
    loadCheck("tcntFrozen", A_TCNT, 32'h5);
    loadCheck("tctrlFrozen", A_TCTRL, 32'h0);

    // Reset in the middle of a running count with pending interrupt
    applyStimulus(A_LEDR, 32'h3FF);
    applyStimulus(A_TCTRL, 32'h100);
    applyStimulus(A_TLIM, 32'h3);
    repeat (7) @(negedge clk);
    loadCheck("preRstTctrl", A_TCTRL, 32'h101);
    checkOutput("preRstIrq", {31'h0, irq}, 32'h1);
    checkOutput("preRstLedr", {22'h0, ledrOut}, 32'h3FF);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("midRstHex", {16'h0, hexOut}, 32'h0);
    checkOutput("midRstLedr", {22'h0, ledrOut}, 32'h0);
    checkOutput("midRstLedg", {24'h0, ledgOut}, 32'h0);
    checkOutput("midRstIrq", {31'h0, irq}, 32'h0);
    loadCheck("midRstTcnt", A_TCNT, 32'h0);
    loadCheck("midRstTlim", A_TLIM, 32'h0);
    loadCheck("midRstTctrl", A_TCTRL, 32'h0);
    loadCheck("midRstKctrl", A_KCTRL, 32'h0);
    loadCheck("midRstSdata", A_SDATA, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
